id_hazard_scoreboard: RTL and testbench

//  Parametrised RAW/WAW hazard scoreboard for the ID stage. It generalises fixed load-use detection to producers
//  of any latency: loads, multi-cycle mul/div, and future long ops.

---
 rtl/id_hazard_scoreboard_if.sv | 43 ++++
 rtl/id_hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_scoreboard_if.sv
// ============================================================================
// Module   : id_hazard_scoreboard_if
// Brief    : ID-stage issue, writeback and stall signals of the hazard scoreboard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_hazard_scoreboard_if #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int NSRC  = 2,
   parameter int LAT_W = 3
);
   logic                 flush;
   logic                 id_valid;
   logic                 id_we;
   logic [AW-1:0]        id_waddr;
   logic [LAT_W-1:0]     id_lat;
   logic [NSRC-1:0]      src_valid;
   logic [NSRC*AW-1:0]   src_addr;
   logic                 down_stall;
   logic                 wb_we;
   logic [AW-1:0]        wb_waddr;
   logic                 stallreq;
   logic                 stall_raw;
   logic                 stall_waw;
   logic                 stall_full;
   logic [NREG-1:0]      busy_vec;

   modport master (
      output flush, id_valid, id_we, id_waddr, id_lat, src_valid, src_addr,
             down_stall, wb_we, wb_waddr,
      input  stallreq, stall_raw, stall_waw, stall_full, busy_vec
   );

   modport slave (
      input  flush, id_valid, id_we, id_waddr, id_lat, src_valid, src_addr,
             down_stall, wb_we, wb_waddr,
      output stallreq, stall_raw, stall_waw, stall_full, busy_vec
   );
endinterface

`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
// ============================================================================
// Module   : id_hazard_scoreboard
// Brief    : Per-register RAW/WAW hazard scoreboard raising stallreq in ID
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_scoreboard #(
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int NSRC   = 2,
   parameter int LAT_W  = 3,
   parameter int PEND_W = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   id_hazard_scoreboard_if.slave hz
);

   localparam logic [PEND_W-1:0] C_PEND_MAX = '1;
   localparam logic [PEND_W-1:0] C_PEND_ONE = PEND_W'(1);
   localparam logic [LAT_W-1:0]  C_LAT_ONE  = LAT_W'(1);

   logic [LAT_W-1:0]  r_cnt  [NREG];
   logic [PEND_W-1:0] r_pend [NREG];

   logic            w_raw;
   logic            w_waw;
   logic            w_full;
   logic            w_stall;
   logic            w_issue;
   logic            w_dst_nz;
   logic [NREG-1:0] w_load_vec;
   logic [NREG-1:0] w_ret_vec;

   // A source at r0 never matches; cnt != 0 means no bypass path holds the value yet.
   always_comb begin
      w_raw = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         w_raw = w_raw | (hz.src_valid[i]
                          && (hz.src_addr[i*AW +: AW] != '0)
                          && (r_cnt[hz.src_addr[i*AW +: AW]] != '0));
      end
      w_raw = w_raw & hz.id_valid;
   end

   assign w_dst_nz = (hz.id_waddr != '0);
   assign w_waw    = hz.id_valid & hz.id_we & w_dst_nz & (r_cnt[hz.id_waddr] > hz.id_lat);
   assign w_full   = hz.id_valid & hz.id_we & w_dst_nz & (r_pend[hz.id_waddr] == C_PEND_MAX);
   assign w_stall  = w_raw | w_waw | w_full;
   assign w_issue  = hz.id_valid & ~w_stall & ~hz.down_stall & ~hz.flush;

   always_comb begin
      w_load_vec = '0;
      w_ret_vec  = '0;
      for (int r = 1; r < NREG; r++) begin
         w_load_vec[r] = w_issue & hz.id_we & (hz.id_waddr == AW'(r));
         w_ret_vec[r]  = hz.wb_we & (hz.wb_waddr == AW'(r)) & (r_pend[r] != '0);
      end
   end

   // Simultaneous issue and retire to one register cancel out in pend.
   always_ff @(posedge clk) begin
      if (rst || hz.flush) begin
         for (int r = 0; r < NREG; r++) begin
            r_cnt[r]  <= '0;
            r_pend[r] <= '0;
         end
      end else begin
         r_cnt[0]  <= '0;
         r_pend[0] <= '0;
         for (int r = 1; r < NREG; r++) begin
            if (w_load_vec[r]) begin
               r_cnt[r] <= hz.id_lat;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - C_LAT_ONE;
            end
            if (w_load_vec[r] && !w_ret_vec[r]) begin
               r_pend[r] <= r_pend[r] + C_PEND_ONE;
            end else if (!w_load_vec[r] && w_ret_vec[r]) begin
               r_pend[r] <= r_pend[r] - C_PEND_ONE;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NREG; g++) begin : g_busy
         if (g == 0) begin : g_zero
            assign hz.busy_vec[g] = 1'b0;
         end else begin : g_track
            assign hz.busy_vec[g] = (r_pend[g] != '0);
         end
      end
   endgenerate

   assign hz.stall_raw  = w_raw;
   assign hz.stall_waw  = w_waw;
   assign hz.stall_full = w_full;
   assign hz.stallreq   = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_id_hazard_scoreboard
// Brief    : Directed plus randomized self-checking bench for id_hazard_scoreboard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_hazard_scoreboard;

   localparam int NREG   = 32;
   localparam int AW     = 5;
   localparam int NSRC   = 2;
   localparam int LAT_W  = 3;
   localparam int PEND_W = 2;
   localparam int PMAX   = (1 << PEND_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int   m_cnt  [NREG];
   int   m_pend [NREG];

   id_hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .LAT_W(LAT_W)) hz ();

   id_hazard_scoreboard #(
      .NREG(NREG), .AW(AW), .NSRC(NSRC), .LAT_W(LAT_W), .PEND_W(PEND_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      hz.flush      = 1'b0;
      hz.id_valid   = 1'b0;
      hz.id_we      = 1'b0;
      hz.id_waddr   = '0;
      hz.id_lat     = '0;
      hz.src_valid  = '0;
      hz.src_addr   = '0;
      hz.down_stall = 1'b0;
      hz.wb_we      = 1'b0;
      hz.wb_waddr   = '0;
   endtask

   task automatic set_dest(input int addr, input int lat);
      hz.id_valid = 1'b1;
      hz.id_we    = 1'b1;
      hz.id_waddr = AW'(addr);
      hz.id_lat   = LAT_W'(lat);
   endtask

   // Check every output against the reference model, then advance one clock.
   task automatic step();
      bit          e_raw, e_waw, e_full, e_req, issue, load, ret;
      logic [31:0] e_busy;
      int          a, d;
      #2;
      e_raw = 0;
      for (int i = 0; i < NSRC; i++) begin
         a = int'(hz.src_addr[i*AW +: AW]);
         if (hz.id_valid && hz.src_valid[i] && a != 0 && m_cnt[a] > 0) e_raw = 1;
      end
      d      = int'(hz.id_waddr);
      e_waw  = hz.id_valid && hz.id_we && d != 0 && m_cnt[d] > int'(hz.id_lat);
      e_full = hz.id_valid && hz.id_we && d != 0 && m_pend[d] == PMAX;
      e_req  = e_raw || e_waw || e_full;
      e_busy = '0;
      for (int r = 1; r < NREG; r++) e_busy[r] = (m_pend[r] > 0);
      check_eq("stall_raw",  64'(hz.stall_raw),  64'(e_raw));
      check_eq("stall_waw",  64'(hz.stall_waw),  64'(e_waw));
      check_eq("stall_full", 64'(hz.stall_full), 64'(e_full));
      check_eq("stallreq",   64'(hz.stallreq),   64'(e_req));
      check_eq("busy_vec",   64'(hz.busy_vec),   64'(e_busy));
      issue = hz.id_valid && !e_req && !hz.down_stall && !hz.flush;
      @(posedge clk);
      if (rst || hz.flush) begin
         for (int r = 0; r < NREG; r++) begin
            m_cnt[r]  = 0;
            m_pend[r] = 0;
         end
      end else begin
         for (int r = 1; r < NREG; r++) begin
            load = issue && hz.id_we && d == r;
            ret  = hz.wb_we && int'(hz.wb_waddr) == r && m_pend[r] > 0;
            m_cnt[r]  = load ? int'(hz.id_lat) : (m_cnt[r] > 0 ? m_cnt[r] - 1 : 0);
            m_pend[r] = m_pend[r] + int'(load) - int'(ret);
         end
      end
      #1;
   endtask

   initial begin
      for (int r = 0; r < NREG; r++) begin
         m_cnt[r]  = 0;
         m_pend[r] = 0;
      end
      set_idle();
      rst = 1'b1;
      @(posedge clk); #1;
      step(); step();
      rst = 1'b0;

      // Reset state: any src/dest shows no stall and nothing busy.
      set_dest(7, 3);
      hz.src_valid = 2'b11; hz.src_addr = {5'd7, 5'd12}; hz.down_stall = 1'b1;
      #1;
      check_eq("t1_stallreq", 64'(hz.stallreq), 64'd0);
      check_eq("t1_busy",     64'(hz.busy_vec), 64'd0);
      step();

      // lat=1 producer stalls its dependant for exactly one cycle.
      set_idle(); set_dest(8, 1); step();
      set_idle(); hz.id_valid = 1'b1; hz.src_valid = 2'b01; hz.src_addr = {5'd0, 5'd8};
      #1; check_eq("t2_raw_on", 64'(hz.stall_raw), 64'd1); step();
      #1; check_eq("t2_raw_off", 64'(hz.stall_raw), 64'd0); step();

      // lat=0 producer never stalls; busy until retired.
      set_idle(); set_dest(9, 0); step();
      set_idle(); hz.id_valid = 1'b1; hz.src_valid = 2'b10; hz.src_addr = {5'd9, 5'd0};
      #1;
      check_eq("t3_no_raw", 64'(hz.stallreq), 64'd0);
      check_eq("t3_busy9",  64'(hz.busy_vec[9]), 64'd1);
      step();
      set_idle(); hz.wb_we = 1'b1; hz.wb_waddr = 5'd9; step();
      set_idle(); #1; check_eq("t3_busy9_clr", 64'(hz.busy_vec[9]), 64'd0); step();

      // WAW: older lat=5 write holds off a newer lat=0 write for five cycles.
      set_dest(10, 5); step();
      set_idle(); set_dest(10, 0);
      for (int k = 0; k < 5; k++) begin
         #1; check_eq("t4_waw_on", 64'(hz.stall_waw), 64'd1); step();
      end
      #1; check_eq("t4_waw_off", 64'(hz.stall_waw), 64'd0); step();
      set_idle(); hz.wb_we = 1'b1; hz.wb_waddr = 5'd10; step(); step();
      set_dest(10, 5); step();
      set_idle(); set_dest(10, 5);
      #1; check_eq("t4_waw_equal", 64'(hz.stallreq), 64'd0); step();

      // Pending-write counter saturation on r5.
      set_idle();
      for (int k = 0; k < 3; k++) begin set_dest(5, 0); step(); end
      set_dest(5, 0);
      #1; check_eq("t5_full", 64'(hz.stall_full), 64'd1); step();
      set_idle(); hz.wb_we = 1'b1; hz.wb_waddr = 5'd5; step();
      set_dest(5, 0); hz.wb_we = 1'b1; hz.wb_waddr = 5'd5; step();
      set_idle(); set_dest(5, 0);
      #1; check_eq("t5_pend_kept", 64'(hz.stall_full), 64'd0); step();
      #1; check_eq("t5_full_again", 64'(hz.stall_full), 64'd1); step();

      // Flush clears everything; r0 destinations are never tracked.
      set_idle(); set_dest(3, 4); step();
      set_idle(); hz.flush = 1'b1; hz.id_valid = 1'b1; hz.src_valid = 2'b01; hz.src_addr = {5'd0, 5'd3};
      step();
      hz.flush = 1'b0;
      #1;
      check_eq("t6_busy", 64'(hz.busy_vec), 64'd0);
      check_eq("t6_stall", 64'(hz.stallreq), 64'd0);
      step();
      set_idle();
      for (int k = 0; k < 4; k++) begin
         set_dest(0, 3); hz.src_valid = 2'b11; hz.src_addr = '0;
         #1; check_eq("t6_r0", 64'(hz.stallreq), 64'd0); step();
      end

      // Randomized traffic on a small register window to provoke collisions.
      for (int n = 0; n < 3000; n++) begin
         rst           = ($urandom_range(0, 255) == 0);
         hz.flush      = ($urandom_range(0, 63) == 0);
         hz.id_valid   = ($urandom_range(0, 3) != 0);
         hz.id_we      = ($urandom_range(0, 1) == 1);
         hz.id_waddr   = AW'($urandom_range(0, 7));
         hz.id_lat     = LAT_W'($urandom_range(0, 7));
         hz.src_valid  = NSRC'($urandom_range(0, 3));
         hz.src_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         hz.down_stall = ($urandom_range(0, 3) == 0);
         hz.wb_we      = ($urandom_range(0, 2) == 0);
         hz.wb_waddr   = AW'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
